// File: rtl/onebit_sub_pkg.sv
// ---------------------------------------------------------------------------
// onebit_sub_pkg
// Purpose : shared constants for the onebit_sub leaf subtractor cell.
// Contents: RST_VAL - value loaded into every register of the cell on reset.
// ---------------------------------------------------------------------------
package onebit_sub_pkg;

    localparam logic RST_VAL = 1'b0;

endpackage : onebit_sub_pkg

// File: rtl/onebit_sub_if.sv
// ---------------------------------------------------------------------------
// onebit_sub_if
// Purpose : groups the operand inputs and result outputs of onebit_sub.
// Signals : en, borrow, a, b            -> driven by the master (operand source)
//           start (ONEBIT_SUB_SERIAL_EN) -> driven by the master, marks bit 0
//           d, borrowout                -> combinational result from the slave
//           d_q, borrowout_q, valid_q   -> registered result from the slave
// Macro   : ONEBIT_SUB_SERIAL_EN adds the start signal.
// ---------------------------------------------------------------------------
interface onebit_sub_if;

    logic en;
    logic borrow;
    logic a;
    logic b;
`ifdef ONEBIT_SUB_SERIAL_EN
    logic start;
`endif
    logic d;
    logic borrowout;
    logic d_q;
    logic borrowout_q;
    logic valid_q;

    modport master (
        output en,
        output borrow,
        output a,
        output b,
`ifdef ONEBIT_SUB_SERIAL_EN
        output start,
`endif
        input  d,
        input  borrowout,
        input  d_q,
        input  borrowout_q,
        input  valid_q
    );

    modport slave (
        input  en,
        input  borrow,
        input  a,
        input  b,
`ifdef ONEBIT_SUB_SERIAL_EN
        input  start,
`endif
        output d,
        output borrowout,
        output d_q,
        output borrowout_q,
        output valid_q
    );

endinterface : onebit_sub_if

// File: rtl/onebit_sub_comb.sv
// ---------------------------------------------------------------------------
// onebit_sub_comb
// Purpose : pure combinational 1-bit full subtractor, a - b - borrow.
// Ports   : i_a         minuend bit
//           i_b         subtrahend bit
//           i_borrow    borrow-in (1 = subtract one more)
//           o_d         difference bit
//           o_borrowout borrow-out (result went below zero)
// ---------------------------------------------------------------------------
module onebit_sub_comb (
    input  logic i_a,
    input  logic i_b,
    input  logic i_borrow,
    output logic o_d,
    output logic o_borrowout
);

    assign o_d         = i_a ^ i_b ^ i_borrow;
    // A borrow is needed whenever b plus borrow-in exceeds a.
    assign o_borrowout = (~i_a & i_b) | (~i_a & i_borrow) | (i_b & i_borrow);

endmodule : onebit_sub_comb

// File: rtl/onebit_sub.sv
// ---------------------------------------------------------------------------
// onebit_sub
// Purpose : 1-bit full subtractor leaf cell with combinational and registered
//           outputs; optionally a bit-serial multi-bit subtractor.
// Ports   : clk  rising-edge clock
//           rst  asynchronous active-high reset (registered outputs only)
//           bus  onebit_sub_if.slave: en, borrow, a, b, [start] in;
//                d, borrowout, d_q, borrowout_q, valid_q out
// Macro   : ONEBIT_SUB_SERIAL_EN - adds start and an internal borrow register
//           so operands can be streamed LSB first, one bit per en cycle.
// ---------------------------------------------------------------------------
module onebit_sub
    import onebit_sub_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    onebit_sub_if.slave  bus
);

    logic w_borrow_eff;
    logic w_d;
    logic w_borrowout;
    logic r_d_q;
    logic r_borrowout_q;
    logic r_valid_q;

`ifdef ONEBIT_SUB_SERIAL_EN
    logic r_brw;

    // Select borrow-in: the port on the first bit of a word, the carried borrow afterwards.
    always_comb begin
        w_borrow_eff = 1'b0;
        if (bus.start) begin
            w_borrow_eff = bus.borrow;
        end else begin
            w_borrow_eff = r_brw;
        end
    end

    // Carry the borrow from one serial bit to the next on each enabled edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_brw <= RST_VAL;
        end else if (bus.en) begin
            r_brw <= w_borrowout;
        end else begin
            r_brw <= r_brw;
        end
    end
`else
    assign w_borrow_eff = bus.borrow;
`endif

    onebit_sub_comb u_comb (
        .i_a         (bus.a),
        .i_b         (bus.b),
        .i_borrow    (w_borrow_eff),
        .o_d         (w_d),
        .o_borrowout (w_borrowout)
    );

    // Output registers: load on en, hold otherwise; valid marks the cycle after a load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d_q         <= RST_VAL;
            r_borrowout_q <= RST_VAL;
            r_valid_q     <= RST_VAL;
        end else if (bus.en) begin
            r_d_q         <= w_d;
            r_borrowout_q <= w_borrowout;
            r_valid_q     <= 1'b1;
        end else begin
            r_d_q         <= r_d_q;
            r_borrowout_q <= r_borrowout_q;
            r_valid_q     <= 1'b0;
        end
    end

    assign bus.d           = w_d;
    assign bus.borrowout   = w_borrowout;
    assign bus.d_q         = r_d_q;
    assign bus.borrowout_q = r_borrowout_q;
    assign bus.valid_q     = r_valid_q;

endmodule : onebit_sub

// File: tb/tb_onebit_sub.sv
// ---------------------------------------------------------------------------
// tb_onebit_sub
// Purpose : self-checking bench for onebit_sub (truth table, register
//           load/hold, asynchronous reset, and the serial variant when
//           ONEBIT_SUB_SERIAL_EN is defined).
// ---------------------------------------------------------------------------
module tb_onebit_sub;

    typedef struct {
        logic borrow;
        logic a;
        logic b;
        logic exp_bo;
        logic exp_d;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    vec_t vecs [8];

    onebit_sub_if bus ();

    onebit_sub dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic actual, input logic expected);
        checks = checks + 1;
        if (actual !== expected) begin
            failures = failures + 1;
            $display("FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    task automatic drive(input logic en, input logic borrow, input logic a, input logic b);
        @(negedge clk);
        bus.en     = en;
        bus.borrow = borrow;
        bus.a      = a;
        bus.b      = b;
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // {borrow, a, b} -> {borrowout, d}
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        rst        = 1'b1;
        bus.en     = 1'b0;
        bus.borrow = 1'b0;
        bus.a      = 1'b0;
        bus.b      = 1'b0;
`ifdef ONEBIT_SUB_SERIAL_EN
        bus.start  = 1'b1;
`endif
        #12;
        check("rst_d_q",         bus.d_q,         1'b0);
        check("rst_borrowout_q", bus.borrowout_q, 1'b0);
        check("rst_valid_q",     bus.valid_q,     1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_d",         bus.d,           1'b0);
        check("idle_borrowout", bus.borrowout,   1'b0);
        check("idle_d_q",       bus.d_q,         1'b0);
        check("idle_valid_q",   bus.valid_q,     1'b0);

        // Truth-table sweep with a load after every vector.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, vecs[i].borrow, vecs[i].a, vecs[i].b);
            check($sformatf("tbl%0d_d", i),         bus.d,         vecs[i].exp_d);
            check($sformatf("tbl%0d_borrowout", i), bus.borrowout, vecs[i].exp_bo);
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_d_q", i),         bus.d_q,         vecs[i].exp_d);
            check($sformatf("tbl%0d_borrowout_q", i), bus.borrowout_q, vecs[i].exp_bo);
            check($sformatf("tbl%0d_valid_q", i),     bus.valid_q,     1'b1);
        end

        // Hold: en low for 3 cycles with inputs giving different results.
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check("hold_comb_d", bus.d, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold%0d_d_q", k),         bus.d_q,         1'b1);
            check($sformatf("hold%0d_borrowout_q", k), bus.borrowout_q, 1'b1);
            check($sformatf("hold%0d_valid_q", k),     bus.valid_q,     1'b0);
        end

        // Reload 0-1-1 (d=0, borrowout=1) then assert reset between edges.
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("pre_rst_valid_q", bus.valid_q, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_d_q",         bus.d_q,         1'b0);
        check("async_rst_borrowout_q", bus.borrowout_q, 1'b0);
        check("async_rst_valid_q",     bus.valid_q,     1'b0);
        check("async_rst_comb_d",      bus.d,           1'b0);
        check("async_rst_comb_bo",     bus.borrowout,   1'b1);
        #1;
        rst = 1'b0;

`ifdef ONEBIT_SUB_SERIAL_EN
        // 0x3 - 0x5 LSB first: d stream 0,1,1,1 and final borrow 1.
        begin
            logic [3:0] op_a;
            logic [3:0] op_b;
            logic [3:0] exp_d;
            op_a  = 4'h3;
            op_b  = 4'h5;
            exp_d = 4'hE;
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                bus.start = (j == 0) ? 1'b1 : 1'b0;
                drive(1'b1, 1'b0, op_a[j], op_b[j]);
                check($sformatf("ser_bit%0d_d", j), bus.d, exp_d[j]);
            end
            @(posedge clk);
            #1;
            check("ser_final_borrowout_q", bus.borrowout_q, 1'b1);
            // Carried borrow shows through d with a=b=0, and holds with en low.
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            check("ser_brw_d", bus.d, 1'b1);
            @(posedge clk);
            #1;
            check("ser_brw_hold_d", bus.d, 1'b1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_onebit_sub
